dm_access_unit: RTL
===================

Name: dm_access_unit

Overview:
Parametrised data-memory access unit between the MEM stage and a handshaked data memory. It takes one load/store per request and produces aligned bus addresses, per-lane byte enables and lane-shifted store data. Load data is sign- or zero-extended. Unaligned accesses are either rejected with an error flag or split into two bus beats, selected by parameter. It supersedes the purely combinational byte-enable decoder: it adds bus width/mode generalisation, a request/ack handshake and two-beat splitting.

Parameters:
DATA_W, 32, memory bus and CPU data width; 32 or 64. NB = DATA_W/8 lanes.
ALLOW_UNALIGNED, 0, 0 = misaligned access raises cpu_err; 1 = misaligned access is split across beats.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
cpu_req  input  1  access request; sampled only while cpu_ready=1.
cpu_we  input  1  1 = store, 0 = load.
cpu_addr  input  32  byte address.
cpu_mode  input  3  0 word, 1 hu, 2 hs, 3 bu, 4 bs, 5 dword (DATA_W=64 only).
cpu_wdata  input  DATA_W  store data, right-justified.
cpu_ready  output  1  unit idle; a request is accepted this cycle.
cpu_done  output  1  one-cycle completion pulse.
cpu_err  output  1  valid with cpu_done; misaligned or illegal mode.
cpu_rdata  output  DATA_W  extended load data; valid with cpu_done.
mem_req  output  1  bus request; held until mem_ack.
mem_we  output  1  bus write.
mem_addr  output  32  NB-aligned address.
mem_be  output  NB  lane enables; lane i = byte address offset i.
mem_wdata  output  DATA_W  lane-positioned store data.
mem_ack  input  1  beat complete; mem_rdata valid the same cycle.
mem_rdata  input  DATA_W  read data.

Behaviour:
- States: IDLE, BEAT0, BEAT1, RESP. cpu_ready = (state==IDLE), combinational.
- Reset (async, reset=0): state IDLE. mem_req, mem_we, mem_addr, mem_be, mem_wdata, cpu_done, cpu_err, cpu_rdata are all 0. cpu_ready reads 1 during reset. An in-flight beat is abandoned; any later mem_ack is ignored.
- Size S = 4/2/2/1/1/8 bytes for modes 0..5. off = cpu_addr mod NB.
- Accept (IDLE and cpu_req): latch we, mode, addr and wdata.
  - Illegal mode (6, 7, or 5 with DATA_W=32) -> RESP with err=1.
  - addr mod S != 0 and ALLOW_UNALIGNED=0 -> RESP with err=1. No bus activity in either error case.
  - Otherwise -> BEAT0.
- BEAT0:
  - mem_req=1, mem_addr=addr with low log2(NB) bits cleared.
  - mem_be lanes off..min(off+S,NB)-1 set.
  - Store byte k of wdata goes to lane off+k. Disabled lanes are driven 0.
  - All mem_* outputs stay stable until mem_ack.
  - On mem_ack: capture enabled read lanes. If off+S > NB go to BEAT1, else go to RESP.
- BEAT1:
  - mem_addr = BEAT0 address + NB.
  - mem_be lanes 0..off+S-NB-1 set; remaining store bytes go to lanes 0 upward.
  - On mem_ack: capture lanes, go to RESP.
- mem_req drops in the cycle after the final ack (registered). Exactly one mem_req/mem_ack pair per beat. mem_ack while mem_req=0 is ignored.
- RESP:
  - cpu_done=1 for one cycle, then IDLE.
  - cpu_rdata = assembled bytes. Extension: hs/bs sign-extend from bit 8S-1; hu/bu zero-extend.
  - word on DATA_W=64 sign-extends bit 31. Store, or err=1, gives cpu_rdata=0.
  - cpu_err cleared on the next accept.
- Minimum latency, aligned, with mem_ack in the first mem_req cycle: accept at cycle 0, mem_req cycle 1, cpu_done cycle 2.
- Error latency: cpu_done at cycle 1.
- Address wrap: BEAT1 at 0xFFFFFFFC+NB wraps modulo 2^32.

Test Plan:
DATA_W=32, ALLOW_UNALIGNED=0, word store 0x1000 / 0xDEADBEEF, ack immediate -> cycle1: mem_addr 0x1000, mem_be 1111, mem_wdata 0xDEADBEEF; cycle2: cpu_done=1, cpu_err=0.
bs load 0x1003, mem_rdata 0x80FF1234 -> mem_be 1000, cpu_rdata 0xFFFFFF80. Repeat with bu -> 0x00000080.
hs load 0x2002, mem_rdata 0x80010000 -> mem_be 1100, cpu_rdata 0xFFFF8001. hu on 0x2003 -> no mem_req; cpu_done and cpu_err at cycle1, cpu_rdata 0.
ALLOW_UNALIGNED=1, word store 0x1001 / 0x11223344, mem_ack delayed 3 cycles per beat:
- beat0: mem_addr 0x1000, mem_be 1110, mem_wdata 0x22334400, stable for 4 cycles.
- beat1: mem_addr 0x1004, mem_be 0001, mem_wdata 0x00000011.
- cpu_done one cycle after the second ack.
ALLOW_UNALIGNED=1, word load 0x1003: beat0 mem_rdata 0xAA000000, beat1 mem_rdata 0x00BBCCDD -> cpu_rdata 0xBBCCDDAA.
Reset (0) while in BEAT1 awaiting ack -> mem_req and all outputs 0 immediately, no cpu_done. After reset=1: cpu_ready=1, and a new aligned request completes normally.

Source files
------------

// File: rtl/dm_access_unit.sv
// Data-memory access unit: turns one MEM-stage load/store into one or two
// handshaked bus beats with lane enables, lane-shifted store data and
// extended load data. Misaligned accesses are rejected or split.
module dm_access_unit #(
  parameter int unsigned DATA_W          = 32,
  parameter bit          ALLOW_UNALIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [2:0]        cpu_mode,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned OFFW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t              state;
  logic                we_q;
  logic [2:0]          mode_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rbuf;

  int unsigned         acc_size, acc_off, cur_size, cur_off;
  logic                acc_bad, split;
  logic [NB-1:0]       be0, be1;
  logic [DATA_W-1:0]   wd0, wd1, rd0, rd1;

  // Access size in bytes; 0 flags an illegal mode for this bus width.
  function automatic int unsigned size_of(input logic [2:0] mode);
    case (mode)
      3'd0:       return 4;
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      3'd5:       return (DATA_W == 64) ? 8 : 0;
      default:    return 0;
    endcase
  endfunction

  // Lane enables for the first (lanes off..) or second (lanes 0..) beat.
  function automatic logic [NB-1:0] lane_be(input int unsigned off,
                                            input int unsigned sz,
                                            input logic second);
    logic [NB-1:0] be;
    be = '0;
    for (int unsigned j = 0; j < NB; j++) begin
      if (!second) be[j] = (j >= off) && (j < off + sz);
      else         be[j] = (j + NB < off + sz);
    end
    return be;
  endfunction

  // Store bytes moved onto their lanes; disabled lanes stay zero.
  function automatic logic [DATA_W-1:0] lane_data(input int unsigned off,
                                                  input int unsigned sz,
                                                  input logic second,
                                                  input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int unsigned j = 0; j < NB; j++) begin
      if (!second && j >= off && j < off + sz)
        d[8*j +: 8] = w[8*(j-off) +: 8];
      else if (second && j + NB < off + sz)
        d[8*j +: 8] = w[8*(j+NB-off) +: 8];
    end
    return d;
  endfunction

  // Collect the read bytes a beat contributes into a right-justified value.
  function automatic logic [DATA_W-1:0] gather(input int unsigned off,
                                               input int unsigned sz,
                                               input logic second,
                                               input logic [DATA_W-1:0] rd,
                                               input logic [DATA_W-1:0] acc);
    logic [DATA_W-1:0] r;
    r = acc;
    for (int unsigned k = 0; k < NB; k++) begin
      if (k < sz) begin
        if (!second && off + k < NB)
          r[8*k +: 8] = rd[8*(off+k) +: 8];
        else if (second && off + k >= NB)
          r[8*k +: 8] = rd[8*(off+k-NB) +: 8];
      end
    end
    return r;
  endfunction

  // Sign/zero extension; word is signed so it widens correctly on 64-bit.
  function automatic logic [DATA_W-1:0] extend(input logic [2:0] mode,
                                               input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    int unsigned       top;
    logic              sgn;
    r   = v;
    top = DATA_W;
    sgn = 1'b0;
    case (mode)
      3'd0: begin top = 32; sgn = 1'b1; end
      3'd1: top = 16;
      3'd2: begin top = 16; sgn = 1'b1; end
      3'd3: top = 8;
      3'd4: begin top = 8; sgn = 1'b1; end
      default: top = DATA_W;
    endcase
    for (int unsigned i = 0; i < DATA_W; i++)
      if (i >= top) r[i] = sgn & v[top-1];
    return r;
  endfunction

  assign cpu_ready = (state == IDLE);

  // Decode of the incoming request and of the latched request.
  always_comb begin
    acc_size = size_of(cpu_mode);
    acc_off  = 32'(cpu_addr[OFFW-1:0]);
    acc_bad  = (acc_size == 0) ||
               (!ALLOW_UNALIGNED && ((cpu_addr & 32'(acc_size - 1)) != '0));
    cur_size = size_of(mode_q);
    cur_off  = 32'(addr_q[OFFW-1:0]);
    split    = (cur_off + cur_size > NB);
    be0      = lane_be(acc_off, acc_size, 1'b0);
    wd0      = lane_data(acc_off, acc_size, 1'b0, cpu_wdata);
    be1      = lane_be(cur_off, cur_size, 1'b1);
    wd1      = lane_data(cur_off, cur_size, 1'b1, wdata_q);
    rd0      = gather(cur_off, cur_size, 1'b0, mem_rdata, '0);
    rd1      = gather(cur_off, cur_size, 1'b1, mem_rdata, rbuf);
  end

  // Access sequencer with registered bus and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      mode_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rbuf      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            we_q    <= cpu_we;
            mode_q  <= cpu_mode;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            cpu_err <= 1'b0;
            if (acc_bad) begin
              state     <= RESP;
              cpu_done  <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
            end else begin
              state     <= BEAT0;
              mem_req   <= 1'b1;
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr & ~32'(NB - 1);
              mem_be    <= be0;
              mem_wdata <= wd0;
              rbuf      <= '0;
            end
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            if (split) begin
              // mem_req stays high: the second beat follows back to back.
              state     <= BEAT1;
              mem_addr  <= mem_addr + 32'(NB);
              mem_be    <= be1;
              mem_wdata <= wd1;
              rbuf      <= rd0;
            end else begin
              state     <= RESP;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_be    <= '0;
              mem_wdata <= '0;
              cpu_done  <= 1'b1;
              cpu_rdata <= we_q ? '0 : extend(mode_q, rd0);
            end
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            cpu_done  <= 1'b1;
            cpu_rdata <= we_q ? '0 : extend(mode_q, rd1);
          end
        end
        RESP: begin
          cpu_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
